// File: rtl/dmem_resp_pkg.sv
// Shared constants and types for the dmem_resp data-memory responder.
// Optional feature macro: DMEM_ACCESS_CNT_EN (read/write access counters).
package dmem_resp_pkg;

    localparam int          BUS_DATA_WIDTH_DEF = 32;
    localparam int          BUS_ADDR_WIDTH_DEF = 32;
    localparam int          WORD_OFF           = 2;      // byte-to-word address shift
    localparam int          DMEM_DEPTH_DEF     = 1024;   // words
    localparam logic [31:0] DMEM_BASE_DEF      = 32'h0000_0000;
    localparam int          CNT_WIDTH          = 32;

    // Source of the registered load data presented to the initiator.
    typedef enum logic {
        SEL_HOLD = 1'b0,   // hold register (previous value, or zero after a bad read)
        SEL_RAM  = 1'b1    // array read port (last cycle was a good read)
    } out_sel_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Load/store bus between the core's memory interface (master) and a responder (slave).
// Every cycle is an access: i_bus_we selects write or read.
interface dmem_resp_if
    import dmem_resp_pkg::*;
#(
    parameter int DW = BUS_DATA_WIDTH_DEF,
    parameter int AW = BUS_ADDR_WIDTH_DEF
);
    logic          i_bus_we;
    logic [AW-1:0] i_bus_addr;
    logic [DW-1:0] i_bus_data;
    logic [DW-1:0] o_bus_data;

    modport master (
        output i_bus_we,
        output i_bus_addr,
        output i_bus_data,
        input  o_bus_data
    );

    modport slave (
        input  i_bus_we,
        input  i_bus_addr,
        input  i_bus_data,
        output o_bus_data
    );
endinterface

// File: rtl/dmem_resp_sp_ram.sv
// Single-port word array: synchronous write, synchronous read-first, no reset.
module dmem_resp_sp_ram #(
    parameter  int DW     = 32,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DW-1:0]     i_wdata,
    output logic [DW-1:0]     o_rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Array write and registered read share one address port.
    // NOTE: the array has no reset branch on purpose; resetting a memory forces it into flops.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
        rdata_q <= mem_q[i_addr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: window decode, registered load data, sticky
// access-error capture, and (with DMEM_ACCESS_CNT_EN) saturating access counters.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int                        BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
    parameter int                        BUS_ADDR_WIDTH = BUS_ADDR_WIDTH_DEF,
    parameter int                        MEM_DEPTH      = DMEM_DEPTH_DEF,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = BUS_ADDR_WIDTH'(DMEM_BASE_DEF)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    dmem_resp_if.slave                bus,
    input  logic                      i_err_clr,
    output logic                      o_err,
    output logic [BUS_ADDR_WIDTH-1:0] o_err_addr
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      o_rd_cnt,
    output logic [CNT_WIDTH-1:0]      o_wr_cnt
`endif
);

    localparam int                        IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [BUS_ADDR_WIDTH-1:0] WIN_BYTES = BUS_ADDR_WIDTH'(MEM_DEPTH) << WORD_OFF;

    logic [BUS_ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]          idx;
    logic                      hit;
    logic                      align;
    logic                      ok;

    logic [BUS_DATA_WIDTH-1:0] ram_rdata;
    logic [BUS_DATA_WIDTH-1:0] rdata;

    out_sel_e                  sel_q, sel_d;
    logic [BUS_DATA_WIDTH-1:0] hold_q, hold_d;
    logic                      err_q, err_d;
    logic [BUS_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    // Window decode: offset wraps modulo 2^BUS_ADDR_WIDTH, so addresses below the base never hit.
    // NOTE: combinational blocks use blocking '=' and sequential blocks use non-blocking '<='.
    always_comb begin
        off   = bus.i_bus_addr - BASE_ADDR;
        hit   = (bus.i_bus_addr >= BASE_ADDR) && (off < WIN_BYTES);
        align = (bus.i_bus_addr[WORD_OFF-1:0] == '0);
        ok    = hit && align;
        idx   = off[IDX_W+WORD_OFF-1:WORD_OFF];
    end

    dmem_resp_sp_ram #(
        .DW    (BUS_DATA_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (bus.i_bus_we && ok),
        .i_addr  (idx),
        .i_wdata (bus.i_bus_data),
        .o_rdata (ram_rdata)
    );

    // Load data comes straight from the array after a good read, otherwise from the hold register.
    always_comb begin
        rdata = (sel_q == SEL_RAM) ? ram_rdata : hold_q;
    end

    assign bus.o_bus_data = rdata;

    // Next output source: writes freeze the current value, bad reads return zero.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        sel_d  = SEL_HOLD;
        hold_d = rdata;
        if (!bus.i_bus_we) begin
            if (ok) begin
                sel_d = SEL_RAM;
            end else begin
                hold_d = '0;
            end
        end
    end

    // Sticky error with first-error address capture; a new error beats a simultaneous clear.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (!ok) begin
            err_d = 1'b1;
            if (!err_q || i_err_clr) begin
                err_addr_d = bus.i_bus_addr;
            end
        end else if (i_err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
    end

    // Output-path and error state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_q      <= SEL_HOLD;
            hold_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign o_err      = err_q;
    assign o_err_addr = err_addr_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

    // Count good accesses only; counters stick at all-ones.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (ok) begin
            if (bus.i_bus_we) begin
                wr_cnt_d = sat_inc(wr_cnt_q);
            end else begin
                rd_cnt_d = sat_inc(rd_cnt_q);
            end
        end
    end

    // Counter registers, cleared by reset only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign o_rd_cnt = rd_cnt_q;
    assign o_wr_cnt = wr_cnt_q;
`endif

endmodule
